// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision adder that reuses one 4-bit adder plus a carry flop, one nibble per clock, LSB first.
// Optional NIBBLE_SERIAL_SUBTRACT_EN adds a sub port (a - b via inverted b and carry-in of 1).
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
  input  logic                 sub,
`endif
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 carry_out,
  output logic                 overflow
);
  localparam int W  = 4*NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q, b_eff;
  logic          sub_q, sub_in, carry_q;
  logic [IW-1:0] idx;
  logic [3:0]    a_nib, b_nib;
  logic [4:0]    nib_sum;
  logic          last, ovf_nxt, accept;

`ifdef NIBBLE_SERIAL_SUBTRACT_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Subtraction is a + ~b + 1; the +1 comes from the preset carry register.
  assign b_eff  = b_q ^ {W{sub_q}};
  assign last   = (idx == IW'(NIBBLES-1));
  assign accept = (state == S_IDLE) && start;

  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_eff[4*i +: 4];
      end
    end
    nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'h0, carry_q};
    // On the last nibble, nib_sum[3] is the sum MSB.
    ovf_nxt = (~a_q[W-1] & ~b_eff[W-1] &  nib_sum[3]) |
              ( a_q[W-1] &  b_eff[W-1] & ~nib_sum[3]);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      sum       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_q       <= a;
      b_q       <= b;
      sub_q     <= sub_in;
      sum       <= '0;
      carry_q   <= sub_in;
      idx       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == S_RUN) begin
      for (int i = 0; i < NIBBLES; i++)
        if (idx == IW'(i)) sum[4*i +: 4] <= nib_sum[3:0];
      carry_q <= nib_sum[4];
      if (last) begin
        carry_out <= nib_sum[4];
        overflow  <= ovf_nxt;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule
